ir_sequencer: RTL and testbench
===============================

# ir_sequencer

Slot sequencer between instruction fetch and execute. It accepts 64-bit instruction words of 16 packed nibbles over a valid/ready handshake and walks them one slot at a time, starting at nibble 0 (`ir[3:0]`). Each step issues one operation: its opcode, its assembled immediate tail, and its nibble position. It is the sequential consumer of the per-nibble tail-length/offset arithmetic, and it presents one op per cycle to the execute stage.

## Interface

- `W`, default 64: instruction word width. Fixed at 16 nibbles; other values are unsupported.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low. Sampled on the rising edge of `clk`.
- `fetch_data` in 64: instruction word. Nibble k is `fetch_data[4k+3:4k]`.
- `fetch_valid` in 1: fetch word available.
- `fetch_ready` out 1: sequencer will take a word this cycle.
- `flush` in 1: discard the current word (branch/redirect).
- `op_valid` out 1: an op is presented.
- `op_ready` in 1: execute accepts the op.
- `op_code` out 4: opcode nibble.
- `op_imm` out 32: sign-extended immediate tail; 0 when the op has no tail.
- `op_pc` out 4: nibble position of the opcode within the word.
- `op_last` out 1: this op ends the word.
- `err` out 1: sticky truncated-tail flag (see Configuration).

## Operation

- **Slot encoding.**
  - `op[3]=0`: no tail, length 0.
  - `op[3]=1`: tail length L = `op[2:0]+1`, range 1..8 nibbles.
  - The tail occupies nibbles pc+1 .. pc+L, little-endian: tail nibble k maps to `op_imm[4k+3:4k]`.
  - The immediate is sign-extended from bit 3 of the last tail nibble.
- **Next slot.** Next pc = pc+1+L.
  - The word ends when next pc > 15, or when the next slot holds opcode `4'h0` (end-of-word padding, never issued).
  - `op_last` is computed the same way, so it is high on the final op.
- **Truncation.** A tail extending past nibble 15 is truncated. Missing nibbles read as 0, and sign extension uses the last nibble actually present. The op is still issued with `op_last=1`.
- **Empty word.** A word whose nibble 0 is `4'h0` issues no op. It is consumed in one cycle.
- **State machine.** Two states: EMPTY and RUN. Registers: `word`, `pc`.
  - **EMPTY.** `fetch_ready=1`, `op_valid=0`. On `fetch_valid`: latch `word`, set pc=0, go to RUN. If nibble 0 is 0, stay EMPTY.
  - **RUN.** `op_valid=1`; `op_*` are driven combinationally from `word`/`pc`.
    - On `op_ready`: if not `op_last`, pc advances to next pc.
    - If `op_last`, the state is released. `fetch_ready = op_valid & op_ready & op_last`, which lets the next word load in the same cycle (zero-bubble).
- **Flush.** Flush has priority over everything else.
  - Next state is EMPTY.
  - A word handshaken in the flush cycle is dropped.
  - An op handshaken in the flush cycle counts as delivered.
- **Reset values.** State EMPTY, pc=0, word=0, err=0. Hence `op_valid=0`, `fetch_ready=1`, `op_code=0`, `op_imm=0`, `op_pc=0`, `op_last=0`.
  - Reset mid-word discards the word with no further ops.

## Timing

- **Latency.** A word accepted on edge N shows its first op in cycle N+1.
- **Throughput.** One op per cycle while `op_ready=1`.
- **Outputs under stall.** `op_*` hold stable while `op_valid & ~op_ready`.
- **Fetch path.** `fetch_ready` is combinational from state, `op_ready` and `flush`: `fetch_ready=0` in any flush cycle. No combinational path from `fetch_valid` to `op_*`.
- **Flush response.** Flush on edge N gives `op_valid=0` in cycle N+1.

## Configuration

- **`IR_SEQ_TRUNC_ERR_EN` defined:** `err` is set on the first cycle a truncated op is presented with `op_valid`. It stays set until reset; flush does not clear it.
- **`IR_SEQ_TRUNC_ERR_EN` undefined:** `err` is tied to 0 and no truncation-detect logic is built. Truncated ops are issued identically in both builds.

## Structure

- **Package `quark_ir_pkg`:**
  - `NIBBLES=16`, `MAX_TAIL=8`, `OP_EOW=4'h0`.
  - State enum `seq_state_t` {EMPTY, RUN}.
- **Sub-module `ir_slot_decode`:** combinational.
  - Inputs: `word`, `pc`.
  - Outputs: `op_code`, tail length, `op_imm`, next pc, `last`, `trunc`.

## Test plan

- **Basic walk.** Word `64'h0000_0000_0005_4A21`, `op_ready=1` → ops (pc0, code1, imm0), (pc1, code2, imm0), (pc2, codeA, imm `32'h54`, last=1). `fetch_ready=1` on the third op.
- **Sign extension.** Word `64'h0000_0000_0000_00F8` → single op: pc0, code8, imm `32'hFFFF_FFFF`, last=1.
- **Truncation.** Word `64'hB111_1111_1111_1111` → ops code1 at pc0..14, then code B at pc15 with imm 0 and last=1. `err` rises only with the macro defined.
- **Backpressure and back-to-back.** Hold `op_ready=0` for 3 cycles on op 2 → outputs stable. Then release with the next word on `fetch_valid` → its op 0 appears the cycle after the last op of the current word, with no bubble.
- **Flush.** Assert `flush` while presenting op 1 of a 3-op word, with `fetch_valid=1` in the same cycle → `op_valid=0` next cycle, offered word dropped, `fetch_ready=1`.
- **Reset mid-word.** Assert `rst_n=0` for one edge mid-word → all outputs at reset values next cycle; `err` cleared.

Source files
------------

// File: rtl/quark_ir_pkg.sv
// Shared constants and types for the instruction-word slot sequencer.
package quark_ir_pkg;

    localparam int NIBBLES  = 16;
    localparam int MAX_TAIL = 8;

    // Opcode nibble that marks end-of-word padding; it is never issued.
    localparam logic [3:0] OP_EOW = 4'h0;

    typedef enum logic {
        EMPTY = 1'b0,
        RUN   = 1'b1
    } seq_state_t;

endpackage

// File: rtl/ir_slot_decode.sv
// Combinational decode of one slot of a 16-nibble instruction word.
// Given the word and an opcode position it produces the opcode, the tail
// length, the sign-extended immediate and the next slot position. It also
// flags whether this is the final op of the word and whether the tail runs
// past nibble 15.
module ir_slot_decode
    import quark_ir_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] word,
    input  logic [3:0]   pc,
    output logic [3:0]   op_code,
    output logic [3:0]   tail_len,
    output logic [31:0]  op_imm,
    output logic [3:0]   next_pc,
    output logic         last,
    output logic         trunc
);

    logic [3:0] nib [NIBBLES];
    logic [3:0] tail_nib [MAX_TAIL];
    logic [4:0] next_pc_full;
    logic [4:0] avail;
    logic [3:0] present;
    logic [2:0] sign_idx;
    logic       sign_bit;

    // Split the word into addressable nibbles.
    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign nib[gi] = word[4*gi +: 4];
        end
    endgenerate

    assign op_code  = nib[pc];
    assign tail_len = op_code[3] ? ({1'b0, op_code[2:0]} + 4'd1) : 4'd0;

    // Five bits wide: pc+1+L can reach 24 before truncation is considered.
    assign next_pc_full = {1'b0, pc} + 5'd1 + {1'b0, tail_len};
    assign next_pc      = next_pc_full[3:0];

    // The tail ends at nibble pc+L = next_pc_full-1; past 15 it is cut off.
    assign trunc   = (next_pc_full > 5'd16);
    assign avail   = 5'd15 - {1'b0, pc};
    assign present = trunc ? avail[3:0] : tail_len;

    // Gather the tail nibbles that actually exist inside the word.
    generate
        for (gi = 0; gi < MAX_TAIL; gi++) begin : g_tail
            logic [4:0] src;
            assign src          = {1'b0, pc} + 5'd1 + 5'(gi);
            assign tail_nib[gi] = (4'(gi) < present) ? nib[src[3:0]] : 4'h0;
        end
    endgenerate

    // Sign comes from the last nibble present; a fully missing tail reads 0.
    assign sign_idx = present[2:0] - 3'd1;
    assign sign_bit = (present != 4'd0) ? tail_nib[sign_idx][3] : 1'b0;

    // Assemble the immediate: present nibbles, then sign fill above them.
    generate
        for (gi = 0; gi < MAX_TAIL; gi++) begin : g_imm
            assign op_imm[4*gi +: 4] = (4'(gi) < present) ? tail_nib[gi] : {4{sign_bit}};
        end
    endgenerate

    // A word ends when the next slot falls off the end or is padding.
    assign last = (next_pc_full > 5'd15) || (nib[next_pc_full[3:0]] == OP_EOW);

endmodule

// File: rtl/ir_sequencer.sv
// Slot sequencer between fetch and execute: takes 64-bit words of 16 packed
// nibbles and issues one op per cycle, starting at nibble 0. The next word
// may load in the same cycle the last op of the current word is accepted.
// Optional build macro: IR_SEQ_TRUNC_ERR_EN enables the sticky err flag for
// ops whose immediate tail runs past nibble 15.
module ir_sequencer
    import quark_ir_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] fetch_data,
    input  logic         fetch_valid,
    output logic         fetch_ready,
    input  logic         flush,
    output logic         op_valid,
    input  logic         op_ready,
    output logic [3:0]   op_code,
    output logic [31:0]  op_imm,
    output logic [3:0]   op_pc,
    output logic         op_last,
    output logic         err
);

    seq_state_t   state_q, state_d;
    logic [W-1:0] word_q, word_d;
    logic [3:0]   pc_q, pc_d;

    logic [3:0]   dec_code;
    logic [3:0]   dec_tail_len;
    logic [31:0]  dec_imm;
    logic [3:0]   dec_next_pc;
    logic         dec_last;
    logic         dec_trunc;

    logic         op_fire;
    logic         fetch_fire;

    ir_slot_decode #(
        .W (W)
    ) u_decode (
        .word     (word_q),
        .pc       (pc_q),
        .op_code  (dec_code),
        .tail_len (dec_tail_len),
        .op_imm   (dec_imm),
        .next_pc  (dec_next_pc),
        .last     (dec_last),
        .trunc    (dec_trunc)
    );

    // Handshakes and op presentation; op fields read zero while idle.
    always_comb begin
        op_valid    = (state_q == RUN);
        op_fire     = op_valid & op_ready;
        fetch_ready = ~flush & (~op_valid | (op_fire & dec_last));
        fetch_fire  = fetch_valid & fetch_ready;
        op_code     = op_valid ? dec_code : 4'h0;
        op_imm      = op_valid ? dec_imm  : 32'h0;
        op_pc       = op_valid ? pc_q     : 4'h0;
        op_last     = op_valid & dec_last;
    end

    // Next-state logic: flush wins, then word load, then slot advance.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        pc_d    = pc_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (fetch_fire) begin
            word_d  = fetch_data;
            pc_d    = 4'd0;
            // A word starting with padding carries no ops and is consumed now.
            state_d = (fetch_data[3:0] == OP_EOW) ? EMPTY : RUN;
        end else if (op_fire) begin
            if (dec_last) begin
                state_d = EMPTY;
            end else begin
                pc_d = dec_next_pc;
            end
        end
    end

    // State, word and slot-position registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            word_q  <= '0;
            pc_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            pc_q    <= pc_d;
        end
    end

`ifdef IR_SEQ_TRUNC_ERR_EN
    logic err_q, err_d;
    logic unused_dec;

    assign unused_dec = ^dec_tail_len;

    // Sticky flag: any truncated op shown to execute; only reset clears it.
    always_comb begin
        err_d = err_q | (op_valid & dec_trunc);
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_dec;

    assign unused_dec = ^{dec_tail_len, dec_trunc};
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_ir_sequencer.sv
// Self-checking bench for ir_sequencer: expected ops are queued when a word
// is offered and compared against every presented op.
module tb_ir_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] fetch_data;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        flush;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_code;
    logic [31:0] op_imm;
    logic [3:0]  op_pc;
    logic        op_last;
    logic        err;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] imm;
        logic [3:0]  pc;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   rand_mode = 0;
    bit   seen_trunc = 0;

`ifdef IR_SEQ_TRUNC_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    ir_sequencer #(.W(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .flush       (flush),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .op_imm      (op_imm),
        .op_pc       (op_pc),
        .op_last     (op_last),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] code, input logic [31:0] imm,
                        input logic [3:0] pc, input logic last);
        exp_t e;
        e.code = code; e.imm = imm; e.pc = pc; e.last = last;
        sb.push_back(e);
    endtask

    // Reference walk of one word; returns 1 if any op's tail was cut off.
    function automatic bit model_word(input logic [63:0] w);
        int p, len, np, nb;
        logic [63:0] acc;
        logic [3:0]  code;
        bit          tr;
        exp_t        e;
        p = 0;
        tr = 0;
        while (p < 16) begin
            code = 4'(w >> (4 * p));
            if (p == 0 && code == 4'h0) break;
            len = code[3] ? int'(code[2:0]) + 1 : 0;
            acc = 64'h0;
            nb  = 0;
            for (int k = 0; k < len; k++) begin
                if (p + 1 + k < 16) begin
                    acc |= ((w >> (4 * (p + 1 + k))) & 64'hF) << (4 * k);
                    nb += 4;
                end else begin
                    tr = 1;
                end
            end
            if (nb > 0 && acc[nb-1]) acc |= ~((64'd1 << nb) - 64'd1);
            np = p + 1 + len;
            e.code = code;
            e.imm  = acc[31:0];
            e.pc   = 4'(p);
            e.last = (np > 15) ? 1'b1 : (4'(w >> (4 * np)) == 4'h0);
            sb.push_back(e);
            if (e.last) break;
            p = np;
        end
        return tr;
    endfunction

    // Mid-cycle monitor: fetch_ready rule and every presented op vs queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            check("fetch_ready", fetch_ready,
                  !flush && (!op_valid || (op_ready && op_last)));
            if (op_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_op", op_valid, 1'b0);
                end else begin
                    check("op_code", op_code, sb[0].code);
                    check("op_imm",  op_imm,  sb[0].imm);
                    check("op_pc",   op_pc,   sb[0].pc);
                    check("op_last", op_last, sb[0].last);
                    if (op_ready) begin
                        $display("op pc=%0d code=%h imm=%h last=%0b",
                                 op_pc, op_code, op_imm, op_last);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [63:0] w);
        bit accepted = 0;
        fetch_data  = w;
        fetch_valid = 1'b1;
        for (int i = 0; i < 100 && !accepted; i++) begin
            if (rand_mode) op_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (fetch_ready) accepted = 1;
            tick();
        end
        fetch_valid = 1'b0;
        check("fetch_accept", accepted, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() > 0; i++) begin
            if (rand_mode) op_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        check("drain_left", sb.size(), 0);
        op_ready = 1'b1;
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_op_valid"},    op_valid,    1'b0);
        check({tag, "_fetch_ready"}, fetch_ready, 1'b1);
        check({tag, "_op_code"},     op_code,     4'h0);
        check({tag, "_op_imm"},      op_imm,      32'h0);
        check({tag, "_op_pc"},       op_pc,       4'h0);
        check({tag, "_op_last"},     op_last,     1'b0);
        check({tag, "_err"},         err,         1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        fetch_data  = 64'h0;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        op_ready    = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check_reset_vals("reset");

        // Basic walk.
        push(4'h1, 32'h0,  4'd0, 1'b0);
        push(4'h2, 32'h0,  4'd1, 1'b0);
        push(4'hA, 32'h54, 4'd2, 1'b1);
        send_word(64'h0000_0000_0005_4A21);
        drain();

        // Sign extension.
        push(4'h8, 32'hFFFF_FFFF, 4'd0, 1'b1);
        send_word(64'h0000_0000_0000_00F8);
        drain();
        check("err_before_trunc", err, 1'b0);

        // Empty word: consumed with no op.
        send_word(64'h1234_0000_0000_0000);
        check("empty_no_op", op_valid, 1'b0);

        // Truncation at nibble 15.
        for (int p = 0; p < 15; p++) push(4'h1, 32'h0, 4'(p), 1'b0);
        push(4'hB, 32'h0, 4'd15, 1'b1);
        send_word(64'hB111_1111_1111_1111);
        seen_trunc = 1;
        drain();
        check("err_after_trunc", err, ERR_EN);

        // Backpressure on op 2 then back-to-back next word.
        push(4'h1, 32'h0,  4'd0, 1'b0);
        push(4'h2, 32'h0,  4'd1, 1'b0);
        push(4'hA, 32'h54, 4'd2, 1'b1);
        push(4'h8, 32'hFFFF_FFFF, 4'd0, 1'b1);
        send_word(64'h0000_0000_0005_4A21);
        tick();
        op_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_valid", op_valid, 1'b1);
            check("stall_code",  op_code,  4'h2);
            check("stall_pc",    op_pc,    4'd1);
            check("stall_imm",   op_imm,   32'h0);
            tick();
        end
        op_ready = 1'b1;
        send_word(64'h0000_0000_0000_00F8);
        check("b2b_valid", op_valid, 1'b1);
        check("b2b_pc",    op_pc,    4'd0);
        check("b2b_code",  op_code,  4'h8);
        drain();

        // Flush on op 1 with a word offered in the same cycle.
        push(4'h1, 32'h0,  4'd0, 1'b0);
        push(4'h2, 32'h0,  4'd1, 1'b0);
        push(4'hA, 32'h54, 4'd2, 1'b1);
        send_word(64'h0000_0000_0005_4A21);
        tick();
        flush       = 1'b1;
        fetch_valid = 1'b1;
        fetch_data  = 64'h0000_0000_0000_00F8;
        #1;
        check("flush_fetch_ready", fetch_ready, 1'b0);
        tick();
        flush       = 1'b0;
        fetch_valid = 1'b0;
        check("flush_left", sb.size(), 1);
        sb.delete();
        #1;
        check("flush_op_valid",    op_valid,    1'b0);
        check("flush_fetch_ready", fetch_ready, 1'b1);
        tick();
        check("flush_dropped", op_valid, 1'b0);

        // Random words, back-to-back, random backpressure.
        rand_mode = 1;
        for (int n = 0; n < 30; n++) begin
            logic [63:0] w;
            for (int k = 0; k < 16; k++)
                w[4*k +: 4] = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if (model_word(w)) seen_trunc = 1;
            send_word(w);
        end
        drain();
        rand_mode = 0;
        check("err_random", err, ERR_EN & seen_trunc);

        // Reset mid-word.
        push(4'h1, 32'h0,  4'd0, 1'b0);
        push(4'h2, 32'h0,  4'd1, 1'b0);
        push(4'hA, 32'h54, 4'd2, 1'b1);
        send_word(64'h0000_0000_0005_4A21);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        #1;
        check_reset_vals("midreset");
        tick();
        check("midreset_idle", op_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
